reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Issue-control scoreboard sitting between the decode stage and the integer register file.
- Tracks which architectural registers have a write in flight and how many writes are outstanding.
- Gates decode issue with a valid/ready handshake, stalling on RAW/WAW hazards and on in-flight capacity.
- Writeback retires entries; a flush from the branch/exception path clears all tracking state.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero, never tracked).
- AW, 5, register address width (log2 NREG).
- MAX_INFLIGHT, 4, maximum outstanding writes before issue is blocked (1..7).
- CW, 3, in-flight counter width (must hold MAX_INFLIGHT).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode presents an instruction
- id_rs1_ena  in  1  instruction reads rs1
- id_rs1_addr  in  AW  rs1 index
- id_rs2_ena  in  1  instruction reads rs2
- id_rs2_addr  in  AW  rs2 index
- id_rd_ena  in  1  instruction writes rd
- id_rd_addr  in  AW  rd index
- id_ready  out  1  issue permitted this cycle; issue fires on id_valid & id_ready
- wb_valid  in  1  writeback retiring a register write this cycle
- wb_addr  in  AW  register being written back
- flush  in  1  discard all in-flight writes
- busy_vec  out  NREG  registered busy bit per register; bit 0 always 0
- inflight_cnt  out  CW  registered count of outstanding writes
- wb_err  out  1  sticky flag: writeback to a non-busy register or to x0

Behaviour:
- Reset (async, rst=1): busy_vec=0, inflight_cnt=0, wb_err=0. id_ready is forced 0 while rst=1.
- Hazard terms, combinational from registered state only. There is no same-cycle writeback bypass.
  - raw1 = id_rs1_ena & busy[rs1].
  - raw2 = id_rs2_ena & busy[rs2].
  - waw = id_rd_ena & busy[rd].
  - full = id_rd_ena & (inflight_cnt == MAX_INFLIGHT).
- Address 0 never produces a hazard.
- id_ready = ~rst & ~flush & ~raw1 & ~raw2 & ~waw & ~full.
- id_ready does not depend on id_valid and is valid when id_valid=0.
- fire = id_valid & id_ready. Setting busy requires wr_fire = fire & id_rd_ena & (rd != 0).
- On a clock edge with wr_fire: busy[rd] <= 1 and inflight_cnt +1.
  - Instructions without rd, or with rd=0, issue without touching state.
- On a clock edge with wb_valid & busy[wb_addr] & wb_addr != 0: busy[wb_addr] <= 0 and inflight_cnt -1.
- Simultaneous wr_fire and valid writeback:
  - Different addresses: both take effect; inflight_cnt unchanged.
  - Same address: cannot occur legally because waw blocks issue. If forced, set wins, counter unchanged, and wb_err is not raised.
- Illegal writeback: wb_valid with wb_addr=0 or a non-busy target leaves busy_vec and inflight_cnt unchanged and sets wb_err=1. wb_err stays 1 until reset.
- Flush has priority over issue and writeback in the same cycle: next state busy_vec=0, inflight_cnt=0. wb_err is kept.
- Latency: a writeback at edge N clears the hazard; a dependent instruction sees id_ready=1 in the cycle after edge N.
- Counter never wraps: increments only when inflight_cnt < MAX_INFLIGHT (guaranteed by full); decrements only with a busy bit set.
- Invariant: inflight_cnt == popcount(busy_vec) at every edge. Verification asserts this.
- Reset asserted mid-operation clears all state immediately, regardless of clk.

Test Plan:
1. Reset, then id_valid with rd=5, rs1=1 (nothing busy) -> id_ready=1; next cycle busy_vec=0x20, inflight_cnt=1.
2. With x5 busy, present rs1=5 -> id_ready=0. Pulse wb_valid, wb_addr=5 -> id_ready=1 the cycle after that edge; inflight_cnt=0.
3. Issue rd=1,2,3,4 back-to-back, then rd=6 -> fifth blocked (full, cnt=4). Same cycle issue rd=0 -> id_ready=1, no state change. Writeback x2 -> rd=6 issues next cycle, cnt stays 4.
4. Same cycle: issue rd=7 and writeback x3 (both busy-consistent) -> busy[7]=1, busy[3]=0, inflight_cnt unchanged.
5. Flush together with id_valid rd=9 and wb_valid x1 -> id_ready=0 that cycle; next cycle busy_vec=0, inflight_cnt=0, x9 not busy.
6. wb_valid to x0, or to non-busy x12 -> wb_err=1 and stays 1; counters unchanged. Assert rst mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/status bundle between the issue stage and the register scoreboard.
// No latency of its own; carries id_ready combinationally back to decode.
// Backpressure: decode holds its instruction while id_ready is low.
interface reg_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            id_valid;
  logic            id_rs1_ena;
  logic [AW-1:0]   id_rs1_addr;
  logic            id_rs2_ena;
  logic [AW-1:0]   id_rs2_addr;
  logic            id_rd_ena;
  logic [AW-1:0]   id_rd_addr;
  logic            id_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic            flush;
  logic [NREG-1:0] busy_vec;
  logic [CW-1:0]   inflight_cnt;
  logic            wb_err;

  // Decode/writeback side drives requests and observes readiness and status.
  modport master (
    output id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
    output id_rd_ena, id_rd_addr, wb_valid, wb_addr, flush,
    input  id_ready, busy_vec, inflight_cnt, wb_err
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_rs1_ena, id_rs1_addr, id_rs2_ena, id_rs2_addr,
    input  id_rd_ena, id_rd_addr, wb_valid, wb_addr, flush,
    output id_ready, busy_vec, inflight_cnt, wb_err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes and gates decode issue on RAW/WAW/capacity.
// id_ready is combinational from registered state; set/clear take effect at the next edge.
// Backpressure: id_ready low on hazard, full, flush or reset; no same-cycle writeback bypass.
module reg_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = 3
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  bus
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic raw1, raw2, waw, full, ready;
  logic wr_fire, wb_ok, wb_bad, same_addr;
  logic inc, dec;

  // Hazard detection and issue decision, purely from registered state.
  always_comb begin
    raw1      = bus.id_rs1_ena & (bus.id_rs1_addr != '0) & busy_q[bus.id_rs1_addr];
    raw2      = bus.id_rs2_ena & (bus.id_rs2_addr != '0) & busy_q[bus.id_rs2_addr];
    waw       = bus.id_rd_ena & (bus.id_rd_addr != '0) & busy_q[bus.id_rd_addr];
    // rd=x0 consumes no tracking slot, so it is never blocked by capacity.
    full      = bus.id_rd_ena & (bus.id_rd_addr != '0) & (cnt_q == CW'(MAX_INFLIGHT));
    ready     = ~rst & ~bus.flush & ~raw1 & ~raw2 & ~waw & ~full;
    wr_fire   = bus.id_valid & ready & bus.id_rd_ena & (bus.id_rd_addr != '0);
    wb_ok     = bus.wb_valid & (bus.wb_addr != '0) & busy_q[bus.wb_addr];
    wb_bad    = bus.wb_valid & ((bus.wb_addr == '0) | ~busy_q[bus.wb_addr]);
    // Only reachable if waw were bypassed; the set wins and the count nets to zero.
    same_addr = wr_fire & wb_ok & (bus.wb_addr == bus.id_rd_addr);
    inc       = wr_fire & ~same_addr;
    dec       = wb_ok & ~same_addr;
  end

  // Next-state: flush wipes tracking, otherwise apply clear then set; error is sticky.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q | wb_bad;
    if (bus.flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end else begin
      if (wb_ok)   busy_d[bus.wb_addr]    = 1'b0;
      if (wr_fire) busy_d[bus.id_rd_addr] = 1'b1;
      cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
    end
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign bus.id_ready     = ready;
  assign bus.busy_vec     = busy_q;
  assign bus.inflight_cnt = cnt_q;
  assign bus.wb_err       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: issue, hazards, capacity, concurrent wb, flush, errors, reset.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
// Each comparison is an immediate assertion that counts and reports failures.
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_scoreboard_if #(.NREG(32), .AW(5), .CW(3)) bus ();

  reg_scoreboard #(.NREG(32), .AW(5), .MAX_INFLIGHT(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1_ena = 0; bus.id_rs1_addr = 0;
    bus.id_rs2_ena = 0; bus.id_rs2_addr = 0; bus.id_rd_ena = 0; bus.id_rd_addr = 0;
    bus.wb_valid = 0; bus.wb_addr = 0; bus.flush = 0;
  endtask

  task automatic state(input string tag, input logic [31:0] busy, input logic [31:0] cnt,
                       input logic [31:0] err);
    chk({tag, "_busy"}, bus.busy_vec, busy);
    chk({tag, "_cnt"}, {29'd0, bus.inflight_cnt}, cnt);
    chk({tag, "_err"}, {31'd0, bus.wb_err}, err);
  endtask

  initial begin
    idle();
    // Reset state; id_ready forced low even with a clean instruction presented.
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 5;
    #2;
    chk("rst_ready", {31'd0, bus.id_ready}, 0);
    state("rst", 32'h0, 0, 0);
    step(); step();
    rst = 0;

    // 1: issue rd=5 reading rs1=1 with nothing busy.
    bus.id_rs1_ena = 1; bus.id_rs1_addr = 1;
    #1;
    chk("t1_ready", {31'd0, bus.id_ready}, 1);
    step();
    idle();
    state("t1", 32'h0000_0020, 1, 0);

    // 2: RAW on x5; writeback in the same cycle does not bypass.
    bus.id_valid = 1; bus.id_rs1_ena = 1; bus.id_rs1_addr = 5;
    #1;
    chk("t2_raw", {31'd0, bus.id_ready}, 0);
    bus.wb_valid = 1; bus.wb_addr = 5;
    #1;
    chk("t2_nobypass", {31'd0, bus.id_ready}, 0);
    step();
    bus.wb_valid = 0;
    #1;
    chk("t2_after_wb", {31'd0, bus.id_ready}, 1);
    state("t2", 32'h0, 0, 0);
    step();
    idle();
    chk("t2_nord_cnt", {29'd0, bus.inflight_cnt}, 0);

    // 3: fill to capacity with rd=1..4.
    for (int i = 1; i <= 4; i++) begin
      bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 5'(i);
      step();
    end
    state("t3_fill", 32'h0000_001E, 4, 0);
    bus.id_rd_addr = 6;
    #1;
    chk("t3_full", {31'd0, bus.id_ready}, 0);
    bus.id_rd_addr = 0;
    #1;
    chk("t3_rd0", {31'd0, bus.id_ready}, 1);
    step();
    state("t3_rd0", 32'h0000_001E, 4, 0);
    bus.id_rd_addr = 6; bus.wb_valid = 1; bus.wb_addr = 2;
    #1;
    chk("t3_full_wb", {31'd0, bus.id_ready}, 0);
    step();
    bus.wb_valid = 0;
    chk("t3_cnt_after_wb", {29'd0, bus.inflight_cnt}, 3);
    #1;
    chk("t3_rd6_ready", {31'd0, bus.id_ready}, 1);
    step();
    idle();
    state("t3_rd6", 32'h0000_005A, 4, 0);

    // 4: free a slot, then issue rd=7 alongside writeback of x3.
    bus.wb_valid = 1; bus.wb_addr = 4;
    step();
    idle();
    state("t4_wb4", 32'h0000_004A, 3, 0);
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 7;
    bus.wb_valid = 1; bus.wb_addr = 3;
    #1;
    chk("t4_ready", {31'd0, bus.id_ready}, 1);
    step();
    idle();
    state("t4", 32'h0000_00C2, 3, 0);

    // 5: flush beats a concurrent issue and writeback.
    bus.flush = 1;
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 9;
    bus.wb_valid = 1; bus.wb_addr = 1;
    #1;
    chk("t5_ready", {31'd0, bus.id_ready}, 0);
    step();
    idle();
    state("t5", 32'h0, 0, 0);

    // 6: WAW and rs2 RAW on x10, then illegal writeback to non-busy x12.
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 10;
    step();
    bus.id_rd_addr = 10;
    #1;
    chk("t6_waw", {31'd0, bus.id_ready}, 0);
    bus.id_rd_ena = 0; bus.id_rs2_ena = 1; bus.id_rs2_addr = 10;
    #1;
    chk("t6_raw2", {31'd0, bus.id_ready}, 0);
    idle();
    bus.wb_valid = 1; bus.wb_addr = 12;
    step();
    idle();
    state("t6_wb12", 32'h0000_0400, 1, 1);
    step();
    chk("t6_sticky", {31'd0, bus.wb_err}, 1);

    // Asynchronous reset between edges clears everything at once.
    bus.id_valid = 1; bus.id_rd_ena = 1; bus.id_rd_addr = 11;
    rst = 1;
    #1;
    state("t6_arst", 32'h0, 0, 0);
    chk("t6_arst_ready", {31'd0, bus.id_ready}, 0);
    step();
    rst = 0;
    idle();

    // Writeback to x0 is illegal and touches no tracking state.
    bus.wb_valid = 1; bus.wb_addr = 0;
    step();
    idle();
    state("t6_wb0", 32'h0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
